apb_master_arb: RTL and testbench

- Round-robin APB master that shares one APB bus between NUM_REQ internal requesters (e.g. CPU bridge, interrupt/debug logic) and the timer's APB slave.
- Sequences the APB SETUP/ACCESS phases and honours slave wait states (pready).
- Returns read data and a one-cycle completion pulse to the granted requester.
- Sits between the requesters and the timer register block's APB slave port.

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/apb_master_arb.sv | 155 +++++++++++++++
 tb/tb_apb_master_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the round-robin APB master.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    // Counter wide enough to hold TIMEOUT_CYC itself.
    function automatic int tmo_cnt_w(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_req_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    assign any_req_o = |req_i;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin APB master sharing one bus between NUM_REQ requesters.
// Optional ACCESS-phase timeout is enabled with `define APB_TIMEOUT_EN.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    apb_state_e           state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [ADDR_W-1:0]    paddr_q;
    logic [DATA_W-1:0]    pwdata_q;
    logic [DATA_W-1:0]    rsp_rdata_q;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;

    logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]    wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_req_o (arb_any)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = tmo_cnt_w(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    localparam int unused_tmo_cyc = TIMEOUT_CYC;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            done_q <= '0;
`ifdef APB_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        state_q  <= ST_SETUP;
                        psel_q   <= 1'b1;
                        gnt_q    <= arb_gnt;
                        ptr_q    <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        pwrite_q <= req_write[arb_idx];
                        paddr_q  <= addr_arr[arb_idx];
                        pwdata_q <= wdata_arr[arb_idx];
`ifdef APB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        state_q   <= ST_DONE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        done_q    <= gnt_q;
                        if (!pwrite_q) begin
                            rsp_rdata_q <= prdata;
                        end
`ifdef APB_TIMEOUT_EN
                    end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        // Slave never answered: complete with error, keep old read data.
                        state_q   <= ST_DONE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        done_q    <= gnt_q;
                        rsp_err_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done      = done_q;
    assign rsp_rdata = rsp_rdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Cycle-level bench for apb_master_arb: directed scenarios plus random traffic
// checked against a transaction-timing model of the arbitrated APB master.
module tb_apb_master_arb;

    localparam int N      = 2;
    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int TB_TMO = 4;
`ifdef APB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic              pready = 1'b0;
    logic [DW-1:0]     prdata = '0;

    always #5 clk = ~clk;

    apb_master_arb #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TB_TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transfer model: k counts cycles since the grant edge (1 = SETUP),
    // an L-cycle ACCESS phase follows, and the done cycle is k = 2+L.
    bit           m_busy = 1'b0;
    int           m_k, m_w, m_len, m_gidx;
    int           m_ptr = 0;
    bit           m_err, m_wr;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [N-1:0]  m_done = '0;
    bit            m_rsp_err = 1'b0;

    int next_w     = 0;
    bit rand_w     = 1'b0;
    bit fix_prdata = 1'b0;

    task automatic step();
        logic [N-1:0]    req_v;
        logic [N-1:0]    wr_v;
        logic [N*AW-1:0] addr_v;
        logic [N*DW-1:0] wd_v;
        logic [DW-1:0]   prdata_v;
        logic            rst_v;
        bit              found;
        bit              exp_psel, exp_pen;
        req_v    = req;
        wr_v     = req_write;
        addr_v   = req_addr;
        wd_v     = req_wdata;
        prdata_v = prdata;
        rst_v    = rst_n;
        @(posedge clk);
        #1;
        m_done    = '0;
        m_rsp_err = 1'b0;
        if (!rst_v) begin
            m_busy  = 1'b0;
            m_ptr   = 0;
            m_addr  = '0;
            m_wdata = '0;
            m_wr    = 1'b0;
            m_rdata = '0;
        end else if (m_busy) begin
            if (m_k == 2 + m_len) begin
                m_busy = 1'b0;
            end else begin
                m_k++;
                if (m_k == 2 + m_len) begin
                    m_done[m_gidx] = 1'b1;
                    m_rsp_err      = m_err;
                    if (!m_err && !m_wr) m_rdata = prdata_v;
                end
            end
        end else if (req_v != '0) begin
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                int idx;
                idx = (m_ptr + j) % N;
                if (!found && req_v[idx]) begin
                    found  = 1'b1;
                    m_gidx = idx;
                end
            end
            m_ptr   = (m_gidx + 1) % N;
            m_wr    = wr_v[m_gidx];
            m_addr  = addr_v[m_gidx*AW +: AW];
            m_wdata = wd_v[m_gidx*DW +: DW];
            m_w     = rand_w ? int'($urandom_range(0, 3)) : next_w;
            m_len   = (TMO_EN && (m_w + 1 > TB_TMO)) ? TB_TMO : m_w + 1;
            m_err   = TMO_EN && (m_w + 1 > TB_TMO);
            m_k     = 1;
            m_busy  = 1'b1;
        end
        exp_psel = m_busy && (m_k >= 1) && (m_k <= 1 + m_len);
        exp_pen  = m_busy && (m_k >= 2) && (m_k <= 1 + m_len);
        check_eq("psel", psel, exp_psel);
        check_eq("penable", penable, exp_pen);
        check_eq("pwrite", pwrite, m_wr);
        check_eq("paddr", paddr, m_addr);
        check_eq("pwdata", pwdata, m_wdata);
        check_eq("done", done, m_done);
        check_eq("done_onehot", ($countones(done) <= 1), 1);
        check_eq("rsp_err", rsp_err, m_rsp_err);
        check_eq("rsp_rdata", rsp_rdata, m_rdata);
        // Slave: answer on ACCESS cycle number m_w (0-based).
        pready = m_busy && (m_k >= 2) && (m_k <= 1 + m_len) && ((m_k - 2) == m_w);
        prdata = fix_prdata ? 32'h0000_00A5 : $urandom;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]              = 1'b1;
        req_write[i]        = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_done(input int bound, output int lat, output logic [N-1:0] d);
        lat = -1;
        d   = '0;
        for (int c = 1; c <= bound; c++) begin
            step();
            if (done != '0) begin
                lat = c;
                d   = done;
                break;
            end
        end
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < N; i++) begin
            if (m_done[i]) begin
                if ($urandom_range(0, 2) == 0) set_req(i, 1'($urandom), AW'($urandom), $urandom);
                else req[i] = 1'b0;
            end else if (!req[i]) begin
                if ($urandom_range(0, 2) == 0) set_req(i, 1'($urandom), AW'($urandom), $urandom);
            end else if (!(m_busy && m_gidx == i)) begin
                if ($urandom_range(0, 3) == 0) set_req(i, 1'($urandom), AW'($urandom), $urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        int           lat;
        int           pcnt;
        logic [N-1:0] d;

        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single write, one wait state.
        next_w = 1;
        set_req(0, 1'b1, 12'h004, 32'hDEADBEEF);
        wait_done(20, lat, d);
        check_eq("wr_latency", lat, 4);
        check_eq("wr_done", d, 2'b01);
        req = '0;
        step();

        // Single read, then a write must not disturb the read data.
        fix_prdata = 1'b1;
        prdata     = 32'h0000_00A5;
        set_req(1, 1'b0, 12'h008, 32'h0);
        wait_done(20, lat, d);
        check_eq("rd_done", d, 2'b10);
        check_eq("rd_data", rsp_rdata, 32'hA5);
        req = '0;
        step();
        set_req(0, 1'b1, 12'h00C, 32'h1234_5678);
        wait_done(20, lat, d);
        req = '0;
        step();
        check_eq("rd_data_kept", rsp_rdata, 32'hA5);
        fix_prdata = 1'b0;

        // Contention from a fresh pointer: strict alternation.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        next_w = 0;
        set_req(0, 1'b1, 12'h010, 32'hAAAA_0000);
        set_req(1, 1'b0, 12'h020, 32'h0);
        for (int t = 0; t < 4; t++) begin
            wait_done(20, lat, d);
            check_eq("rr_order", d, (t % 2 == 0) ? 2'b01 : 2'b10);
        end
        req = '0;
        repeat (2) step();

        // Zero-wait slave.
        set_req(0, 1'b0, 12'h030, 32'h0);
        lat  = -1;
        pcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (psel) pcnt++;
            if (done != '0) begin
                lat = c;
                break;
            end
        end
        check_eq("zw_latency", lat, 3);
        check_eq("zw_psel_cycles", pcnt, 2);
        req = '0;
        step();

        // Slave that stalls far beyond the timeout.
        next_w = 110;
        set_req(0, 1'b0, 12'h040, 32'h0);
        wait_done(300, lat, d);
        check_eq("stall_latency", lat, TMO_EN ? 2 + TB_TMO : 113);
        check_eq("stall_err", rsp_err, TMO_EN);
        req = '0;
        step();

        // Reset in the middle of ACCESS.
        next_w = 50;
        set_req(0, 1'b0, 12'h050, 32'h0);
        repeat (4) step();
        next_w = 1;
        set_req(1, 1'b0, 12'h060, 32'h0);
        rst_n  = 1'b0;
        req[0] = 1'b0;
        step();
        check_eq("rst_psel", psel, 0);
        check_eq("rst_done", done, 0);
        rst_n = 1'b1;
        wait_done(20, lat, d);
        check_eq("rst_regrant", d, 2'b10);
        req = '0;
        step();

        // Random traffic.
        rand_w = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            step();
            rand_reqs();
        end
        req = '0;
        for (int c = 0; c < 20 && m_busy; c++) step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
